// File: rtl/pwr_toggle_accum.sv
// Per-class rising-edge accumulator with snapshot and streamed readout.
// Live counters keep running while the snapshot is dumped one class per beat.
module pwr_toggle_accum #(
  parameter  int N_CLASSES   = 8,
  parameter  int CNT_W       = 16,
  parameter  bit CLR_ON_SNAP = 1'b1,
  localparam int IDX_W       = $clog2(N_CLASSES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_CLASSES-1:0] mon_in,
  input  logic                 enable,
  input  logic                 snap_req,
  output logic                 snap_busy,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [IDX_W-1:0]     rd_idx,
  output logic [CNT_W-1:0]     rd_data,
  output logic                 rd_sat,
  output logic                 rd_last
);

  typedef enum logic {IDLE, DUMP} state_e;

  localparam logic [CNT_W-1:0] MAX  = '1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_CLASSES - 1);

  state_e                            state_q, state_d;
  logic [IDX_W-1:0]                  idx_q, idx_d;
  logic [N_CLASSES-1:0]              mon_prev_q;
  logic [N_CLASSES-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_CLASSES-1:0]              sat_q, sat_d;
  logic [N_CLASSES-1:0][CNT_W-1:0]   shadow_q;
  logic [N_CLASSES-1:0]              shadow_sat_q;

  logic                              snap;
  logic                              clr;
  logic                              dump;
  logic [N_CLASSES-1:0]              rise;
  logic [N_CLASSES-1:0]              inc;
  logic [N_CLASSES-1:0][CNT_W-1:0]   base;
  logic [N_CLASSES-1:0]              base_sat;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (snap_req) begin
          snap    = 1'b1;
          idx_d   = '0;
          state_d = DUMP;
        end
      end
      DUMP: begin
        if (rd_ready) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST) state_d = IDLE;
        end
      end
    endcase
  end

  // Clearing restarts from this cycle's edge so nothing is lost at snapshot.
  always_comb begin
    clr  = snap && CLR_ON_SNAP;
    rise = mon_in & ~mon_prev_q;
    inc  = rise & {N_CLASSES{enable}};
    base     = '0;
    base_sat = '0;
    cnt_d    = '0;
    sat_d    = '0;
    for (int i = 0; i < N_CLASSES; i++) begin
      base[i]     = clr ? '0 : cnt_q[i];
      base_sat[i] = clr ? 1'b0 : sat_q[i];
      cnt_d[i]    = (inc[i] && base[i] != MAX) ? base[i] + 1'b1 : base[i];
      sat_d[i]    = base_sat[i] | (inc[i] && base[i] >= MAX - 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      mon_prev_q   <= '0;
      cnt_q        <= '0;
      sat_q        <= '0;
      shadow_q     <= '0;
      shadow_sat_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mon_prev_q <= mon_in;
      cnt_q      <= cnt_d;
      sat_q      <= sat_d;
      if (snap) begin
        shadow_q     <= cnt_q;
        shadow_sat_q <= sat_q;
      end
    end
  end

  assign dump      = (state_q == DUMP);
  assign snap_busy = dump;
  assign rd_valid  = dump;
  assign rd_idx    = dump ? idx_q : '0;
  assign rd_data   = dump ? shadow_q[idx_q] : '0;
  assign rd_sat    = dump & shadow_sat_q[idx_q];
  assign rd_last   = dump & (idx_q == LAST);

endmodule

// File: tb/tb_pwr_toggle_accum.sv
// Bench for pwr_toggle_accum: 16-bit and 4-bit instances share stimulus
// and are checked against edge totals and a queue of expected beats.
module tb_pwr_toggle_accum;

  localparam int N  = 8;
  localparam int WA = 16;
  localparam int WB = 4;
  localparam int MA = (1 << WA) - 1;
  localparam int MB = (1 << WB) - 1;

  logic          clk = 1'b0;
  logic          reset, enable, snap_req, rd_ready;
  logic [N-1:0]  mon_in;

  logic          a_busy, a_valid, a_sat, a_last;
  logic [2:0]    a_idx;
  logic [WA-1:0] a_data;
  logic          b_busy, b_valid, b_sat, b_last;
  logic [2:0]    b_idx;
  logic [WB-1:0] b_data;

  always #5 clk = ~clk;

  pwr_toggle_accum #(.N_CLASSES(N), .CNT_W(WA), .CLR_ON_SNAP(1'b1)) u_a (
    .clk(clk), .reset(reset), .mon_in(mon_in), .enable(enable),
    .snap_req(snap_req), .snap_busy(a_busy), .rd_valid(a_valid),
    .rd_ready(rd_ready), .rd_idx(a_idx), .rd_data(a_data),
    .rd_sat(a_sat), .rd_last(a_last)
  );

  pwr_toggle_accum #(.N_CLASSES(N), .CNT_W(WB), .CLR_ON_SNAP(1'b1)) u_b (
    .clk(clk), .reset(reset), .mon_in(mon_in), .enable(enable),
    .snap_req(snap_req), .snap_busy(b_busy), .rd_valid(b_valid),
    .rd_ready(rd_ready), .rd_idx(b_idx), .rd_data(b_data),
    .rd_sat(b_sat), .rd_last(b_last)
  );

  typedef struct {
    int idx;
    int da;
    bit sa;
    int db;
    bit sb;
  } beat_t;

  beat_t        mq[$];
  int           tot[N];
  logic [N-1:0] mprev = '0;
  int           vecs = 0;
  int           errs = 0;

  // Reference: unbounded edge totals since last snapshot; a snapshot
  // queues N beats, each accepted handshake retires the front beat.
  task automatic tick();
    logic [N-1:0] r;
    beat_t b;
    r = mon_in & ~mprev;
    if (reset) begin
      foreach (tot[i]) tot[i] = 0;
      mq.delete();
      mprev = '0;
    end else begin
      if (mq.size() == 0 && snap_req) begin
        for (int i = 0; i < N; i++) begin
          b.idx = i;
          b.da  = (tot[i] > MA) ? MA : tot[i];
          b.sa  = (tot[i] >= MA);
          b.db  = (tot[i] > MB) ? MB : tot[i];
          b.sb  = (tot[i] >= MB);
          mq.push_back(b);
          tot[i] = 0;
        end
      end else if (mq.size() > 0 && rd_ready) begin
        mq.delete(0);
      end
      for (int i = 0; i < N; i++)
        if (enable && r[i]) tot[i]++;
      mprev = mon_in;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic read_dump(string tag, int pct, bit poke, bit noise,
                           output int cyc);
    beat_t e;
    int n;
    n   = 0;
    cyc = 0;
    while (mq.size() > 0 && n < 200) begin
      e = mq[0];
      cyc += int'(a_busy);
      vecs++;
      if ({a_valid, a_busy, b_valid, b_busy} !== 4'hF) begin
        errs++;
        $display("FAIL %s valid/busy got %b%b%b%b want 1111",
                 tag, a_valid, a_busy, b_valid, b_busy);
      end
      vecs++;
      if ({a_idx, a_data, a_sat, a_last} !==
          {3'(e.idx), WA'(e.da), e.sa, e.idx == N - 1}) begin
        errs++;
        $display("FAIL %s beatA got idx=%0d d=%0d s=%0d l=%0d want idx=%0d d=%0d s=%0d",
                 tag, a_idx, a_data, a_sat, a_last, e.idx, e.da, e.sa);
      end
      vecs++;
      if ({b_idx, b_data, b_sat, b_last} !==
          {3'(e.idx), WB'(e.db), e.sb, e.idx == N - 1}) begin
        errs++;
        $display("FAIL %s beatB got idx=%0d d=%0d s=%0d l=%0d want idx=%0d d=%0d s=%0d",
                 tag, b_idx, b_data, b_sat, b_last, e.idx, e.db, e.sb);
      end
      rd_ready = ($urandom_range(99) < pct);
      snap_req = poke && ($urandom_range(3) == 0);
      if (noise) begin
        mon_in = N'($urandom());
        enable = 1'($urandom_range(1));
      end
      tick();
      n++;
    end
    snap_req = 1'b0;
    rd_ready = 1'b0;
    vecs++;
    if (n >= 200) begin
      errs++;
      $display("FAIL %s dump timeout got %0d cycles want <200", tag, n);
    end
    vecs++;
    if ({a_valid, a_busy, b_valid, b_busy} !== 4'h0) begin
      errs++;
      $display("FAIL %s end-of-dump got %b%b%b%b want 0000",
               tag, a_valid, a_busy, b_valid, b_busy);
    end
  endtask

  task automatic snap();
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    vecs++;
    if ({a_busy, a_valid, a_idx, a_data, a_sat, a_last} !== '0) begin
      errs++;
      $display("FAIL reset_a got v=%b b=%b i=%0d d=%0d want all 0",
               a_valid, a_busy, a_idx, a_data);
    end
    vecs++;
    if ({b_busy, b_valid, b_idx, b_data, b_sat, b_last} !== '0) begin
      errs++;
      $display("FAIL reset_b got v=%b b=%b i=%0d d=%0d want all 0",
               b_valid, b_busy, b_idx, b_data);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_pulse();
    int c;
    enable = 1'b1;
    mon_in = '0;
    tick();
    mon_in[0] = 1'b1;
    tick();
    mon_in[0] = 1'b0;
    tick();
    snap();
    vecs++;
    if (a_idx !== 3'd0 || a_data !== 16'd1 || a_last !== 1'b0) begin
      errs++;
      $display("FAIL pulse_beat0 got idx=%0d d=%0d l=%b want idx=0 d=1 l=0",
               a_idx, a_data, a_last);
    end
    read_dump("pulse", 100, 1'b0, 1'b0, c);
  endtask

  task automatic test_toggle();
    int c;
    enable = 1'b1;
    mon_in = '0;
    tick();
    for (int k = 0; k < 40; k++) begin
      mon_in[3] = ~mon_in[3];
      tick();
    end
    snap();
    read_dump("toggle", 100, 1'b0, 1'b0, c);
    vecs++;
    if (c !== 8) begin
      errs++;
      $display("FAIL toggle_busy_len got %0d want 8", c);
    end
  endtask

  task automatic test_saturate();
    int c;
    enable = 1'b1;
    mon_in = '0;
    tick();
    for (int k = 0; k < 40; k++) begin
      mon_in[1] = ~mon_in[1];
      tick();
    end
    snap();
    read_dump("sat1", 100, 1'b0, 1'b0, c);
    mon_in = '0;
    tick();
    snap();
    vecs++;
    if (b_sat !== 1'b0 || b_data !== '0) begin
      errs++;
      $display("FAIL sat_cleared got d=%0d s=%b want d=0 s=0", b_data, b_sat);
    end
    read_dump("sat2", 100, 1'b0, 1'b0, c);
  endtask

  task automatic test_snap_edge();
    int c;
    enable = 1'b1;
    mon_in = '0;
    tick();
    mon_in[2] = 1'b1;
    snap();
    read_dump("edge1", 100, 1'b0, 1'b0, c);
    snap();
    read_dump("edge2", 100, 1'b0, 1'b0, c);
  endtask

  task automatic test_back_to_back();
    int c;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 10 + int'($urandom_range(20)); k++) begin
        mon_in = N'($urandom());
        enable = ($urandom_range(3) != 0);
        tick();
      end
      snap();
      read_dump("bp", 50, 1'b1, 1'b1, c);
    end
  endtask

  task automatic test_reset_mid_dump();
    int c;
    enable = 1'b1;
    for (int k = 0; k < 12; k++) begin
      mon_in = N'($urandom());
      tick();
    end
    snap();
    rd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      vecs++;
      if (a_idx !== 3'(k) || a_valid !== 1'b1) begin
        errs++;
        $display("FAIL mid_beat got idx=%0d v=%b want idx=%0d v=1",
                 a_idx, a_valid, k);
      end
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd_ready = 1'b0;
    vecs++;
    if ({a_valid, b_valid, a_busy, b_busy} !== 4'h0) begin
      errs++;
      $display("FAIL mid_reset got %b%b%b%b want 0000",
               a_valid, b_valid, a_busy, b_busy);
    end
    enable = 1'b0;
    for (int k = 0; k < 16; k++) begin
      mon_in = N'($urandom());
      tick();
    end
    snap();
    read_dump("mid_zero", 100, 1'b0, 1'b0, c);
  endtask

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    snap_req = 1'b0;
    rd_ready = 1'b0;
    mon_in   = '0;
    foreach (tot[i]) tot[i] = 0;
    test_reset();
    test_single_pulse();
    test_toggle();
    test_saturate();
    test_snap_edge();
    test_back_to_back();
    test_reset_mid_dump();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
